// File: rtl/disp_scan_capture.sv
// disp_scan_capture: watches a time-multiplexed 4-digit display bus and rebuilds
// the hex word, point mask and LE mask once every digit has been seen stable.
module disp_scan_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  AN,
    input  logic [3:0]  Hex,
    input  logic        p,
    input  logic        LE,
    input  logic        clr_err,
    output logic [15:0] Hexs,
    output logic [3:0]  point,
    output logic [3:0]  LES,
    output logic        frame_valid,
    output logic [3:0]  seen,
    output logic        an_err
);

    localparam int unsigned SW = 10;
    localparam int unsigned CW = 8;
    localparam int unsigned ND = 4;
    localparam logic [CW-1:0] RUN_MAX    = '1;
    localparam logic [CW-1:0] STABLE     = CW'(STABLE_CYCLES);
    localparam logic [SW-1:0] SAMPLE_RST = {4'b1111, 4'h0, 1'b0, 1'b0};

    logic [SW-1:0]   sample_q, sample_d;
    logic [CW-1:0]   run_q, run_d;
    logic            evt_q, evt_d;
    logic            changed_c;
    logic [4*ND-1:0] shadow_hex_q, shadow_hex_d;
    logic [ND-1:0]   shadow_p_q, shadow_p_d;
    logic [ND-1:0]   shadow_le_q, shadow_le_d;
    logic [4*ND-1:0] hexs_q, hexs_d;
    logic [ND-1:0]   point_q, point_d;
    logic [ND-1:0]   les_q, les_d;
    logic            fv_q, fv_d;
    logic [ND-1:0]   seen_q, seen_d;
    logic            err_q, err_d;
    logic            legal_c, illegal_c;
    logic [1:0]      dig_c;
    logic [ND-1:0]   seen_all_c;

    // Run-length tracking; the event fires once, when the run first reaches STABLE.
    always_comb begin
        sample_d  = {AN, Hex, p, LE};
        changed_c = (sample_d != sample_q);
        run_d     = run_q;
        if (changed_c) begin
            run_d = CW'(1);
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + CW'(1);
        end
        // Saturated run sitting at STABLE (only possible for 255) must not re-fire.
        evt_d = (run_d == STABLE) && (changed_c || (run_q != STABLE));
    end

    // Classify the anode pattern of the stable sample.
    always_comb begin
        legal_c   = 1'b0;
        illegal_c = 1'b0;
        dig_c     = 2'd0;
        case (sample_q[9:6])
            4'b1110: begin legal_c = 1'b1; dig_c = 2'd0; end
            4'b1101: begin legal_c = 1'b1; dig_c = 2'd1; end
            4'b1011: begin legal_c = 1'b1; dig_c = 2'd2; end
            4'b0111: begin legal_c = 1'b1; dig_c = 2'd3; end
            4'b1111: ;
            default: illegal_c = 1'b1;
        endcase
    end

    // Capture into shadows, commit a full frame, and maintain the sticky error.
    always_comb begin
        shadow_hex_d = shadow_hex_q;
        shadow_p_d   = shadow_p_q;
        shadow_le_d  = shadow_le_q;
        hexs_d       = hexs_q;
        point_d      = point_q;
        les_d        = les_q;
        seen_d       = seen_q;
        fv_d         = 1'b0;
        err_d        = err_q;
        seen_all_c   = seen_q | (4'b0001 << dig_c);
        if (evt_q && legal_c) begin
            shadow_hex_d[{dig_c, 2'b00} +: 4] = sample_q[5:2];
            shadow_p_d[dig_c]                 = sample_q[1];
            shadow_le_d[dig_c]                = sample_q[0];
            if (seen_all_c == 4'b1111) begin
                hexs_d  = shadow_hex_d;
                point_d = shadow_p_d;
                les_d   = shadow_le_d;
                seen_d  = '0;
                fv_d    = 1'b1;
            end else begin
                seen_d = seen_all_c;
            end
        end
        if (evt_q && illegal_c) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q     <= SAMPLE_RST;
            run_q        <= '0;
            evt_q        <= 1'b0;
            shadow_hex_q <= '0;
            shadow_p_q   <= '0;
            shadow_le_q  <= '0;
            hexs_q       <= '0;
            point_q      <= '0;
            les_q        <= '0;
            fv_q         <= 1'b0;
            seen_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            sample_q     <= sample_d;
            run_q        <= run_d;
            evt_q        <= evt_d;
            shadow_hex_q <= shadow_hex_d;
            shadow_p_q   <= shadow_p_d;
            shadow_le_q  <= shadow_le_d;
            hexs_q       <= hexs_d;
            point_q      <= point_d;
            les_q        <= les_d;
            fv_q         <= fv_d;
            seen_q       <= seen_d;
            err_q        <= err_d;
        end
    end

    assign Hexs        = hexs_q;
    assign point       = point_q;
    assign LES         = les_q;
    assign frame_valid = fv_q;
    assign seen        = seen_q;
    assign an_err      = err_q;

endmodule

// File: tb/tb_disp_scan_capture.sv
// Bench for disp_scan_capture: two instances (STABLE_CYCLES=4 and =1) driven from
// the same bus, each compared every cycle against a behavioural reference model.
module tb_disp_scan_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] an  = 4'b1111;
    logic [3:0] hex = 4'h0;
    logic       pp  = 1'b0;
    logic       le  = 1'b0;
    logic       clr = 1'b0;

    logic [15:0] hexs0, hexs1;
    logic [3:0]  point0, point1, les0, les1, seen0, seen1;
    logic        fv0, fv1, err0, err1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int fv_cnt = 0;
    int fv_cyc = 0;

    disp_scan_capture #(.STABLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .AN(an), .Hex(hex), .p(pp), .LE(le), .clr_err(clr),
        .Hexs(hexs0), .point(point0), .LES(les0), .frame_valid(fv0),
        .seen(seen0), .an_err(err0)
    );

    disp_scan_capture #(.STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .AN(an), .Hex(hex), .p(pp), .LE(le), .clr_err(clr),
        .Hexs(hexs1), .point(point1), .LES(les1), .frame_valid(fv1),
        .seen(seen1), .an_err(err1)
    );

    initial forever #5 clk = ~clk;

    // Reference model state, one slot per instance.
    int          s_cfg [2] = '{4, 1};
    logic [9:0]  last_m [2];
    int          run_m [2];
    bit          pend_m [2];
    logic [9:0]  pend_smp [2];
    logic [3:0]  sh_hex [2][4];
    bit          sh_p [2][4];
    bit          sh_le [2][4];
    logic [3:0]  seen_m [2];
    logic [15:0] hexs_m [2];
    logic [3:0]  point_m [2];
    logic [3:0]  les_m [2];
    bit          fv_m [2];
    bit          err_m [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset(input int i);
        last_m[i]   = 10'b1111_0000_0_0;
        run_m[i]    = 0;
        pend_m[i]   = 1'b0;
        pend_smp[i] = '0;
        for (int d = 0; d < 4; d++) begin
            sh_hex[i][d] = 4'h0;
            sh_p[i][d]   = 1'b0;
            sh_le[i][d]  = 1'b0;
        end
        seen_m[i]  = 4'h0;
        hexs_m[i]  = 16'h0;
        point_m[i] = 4'h0;
        les_m[i]   = 4'h0;
        fv_m[i]    = 1'b0;
        err_m[i]   = 1'b0;
    endtask

    // One clock edge of the behaviour: act on a digit that became stable last
    // edge, then account the new sample into the current run.
    task automatic model_edge(input int i);
        logic [9:0] smp;
        logic [3:0] a;
        int zeros, k;
        bit set_err;
        smp     = {an, hex, pp, le};
        set_err = 1'b0;
        fv_m[i] = 1'b0;
        if (pend_m[i]) begin
            a = pend_smp[i][9:6];
            zeros = 0;
            k = 0;
            for (int b = 0; b < 4; b++) if (!a[b]) begin zeros++; k = b; end
            if (zeros == 1) begin
                sh_hex[i][k] = pend_smp[i][5:2];
                sh_p[i][k]   = pend_smp[i][1];
                sh_le[i][k]  = pend_smp[i][0];
                seen_m[i][k] = 1'b1;
                if (seen_m[i] == 4'hF) begin
                    for (int d = 0; d < 4; d++) begin
                        hexs_m[i][4*d +: 4] = sh_hex[i][d];
                        point_m[i][d]       = sh_p[i][d];
                        les_m[i][d]         = sh_le[i][d];
                    end
                    seen_m[i] = 4'h0;
                    fv_m[i]   = 1'b1;
                end
            end else if (zeros >= 2) begin
                set_err = 1'b1;
            end
        end
        pend_m[i] = 1'b0;
        if (smp == last_m[i]) run_m[i]++;
        else                  run_m[i] = 1;
        last_m[i] = smp;
        if (run_m[i] == s_cfg[i]) begin
            pend_m[i]   = 1'b1;
            pend_smp[i] = smp;
        end
        if (set_err)  err_m[i] = 1'b1;
        else if (clr) err_m[i] = 1'b0;
    endtask

    task automatic chk_dut(input int i, input logic [15:0] hx, input logic [3:0] pt,
                           input logic [3:0] ls, input logic fv, input logic [3:0] sn,
                           input logic er);
        string pfx;
        pfx = (i == 0) ? "s4" : "s1";
        chk({pfx, "_hexs"},  32'(hx), 32'(hexs_m[i]));
        chk({pfx, "_point"}, 32'(pt), 32'(point_m[i]));
        chk({pfx, "_les"},   32'(ls), 32'(les_m[i]));
        chk({pfx, "_fv"},    32'(fv), 32'(fv_m[i]));
        chk({pfx, "_seen"},  32'(sn), 32'(seen_m[i]));
        chk({pfx, "_err"},   32'(er), 32'(err_m[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else     model_edge(i);
        end
        #1;
        cyc++;
        if (fv0) begin fv_cnt++; fv_cyc = cyc; end
        chk_dut(0, hexs0, point0, les0, fv0, seen0, err0);
        chk_dut(1, hexs1, point1, les1, fv1, seen1, err1);
    endtask

    task automatic hold(input logic [3:0] a, input logic [3:0] h, input logic pv,
                        input logic lv, input int n);
        an = a; hex = h; pp = pv; le = lv;
        repeat (n) tick();
    endtask

    int f0, c3;
    logic [15:0] hx_save;
    logic [3:0]  sn_save;
    logic [3:0]  ra;

    initial begin
        for (int i = 0; i < 2; i++) model_reset(i);
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_hexs",  32'(hexs0),  32'h0);
        chk("rst_seen",  32'(seen0),  32'h0);
        chk("rst_err",   32'(err0),   32'h0);
        chk("rst_fv",    32'(fv0),    32'h0);
        rst = 1'b0;

        // In-order scan 0..3.
        f0 = fv_cnt;
        hold(4'b1110, 4'h1, 1'b1, 1'b0, 8);
        hold(4'b1101, 4'h2, 1'b0, 1'b0, 8);
        hold(4'b1011, 4'h3, 1'b1, 1'b1, 8);
        c3 = cyc + 1;
        hold(4'b0111, 4'h4, 1'b0, 1'b1, 8);
        chk("scan_fv_cnt", 32'(fv_cnt - f0), 32'd1);
        chk("scan_fv_lat", 32'(fv_cyc - c3), 32'd4);
        chk("scan_hexs",   32'(hexs0),  32'h4321);
        chk("scan_point",  32'(point0), 32'b0101);
        chk("scan_les",    32'(les0),   32'b1100);

        // Glitch on digit1.
        hold(4'b1110, 4'h6, 1'b0, 1'b0, 8);
        hold(4'b1101, 4'h5, 1'b0, 1'b0, 1);
        hold(4'b1101, 4'h7, 1'b0, 1'b0, 2);
        hold(4'b1101, 4'h5, 1'b0, 1'b0, 6);
        hold(4'b1011, 4'h8, 1'b0, 1'b0, 8);
        hold(4'b0111, 4'h9, 1'b0, 1'b0, 8);
        chk("glitch_nib", 32'(hexs0[7:4]), 32'h5);
        chk("glitch_word", 32'(hexs0), 32'h9856);

        // Reverse order with digit2 shown twice.
        f0 = fv_cnt;
        hold(4'b0111, 4'hB, 1'b0, 1'b0, 8);
        hold(4'b1011, 4'h9, 1'b0, 1'b0, 8);
        hold(4'b1011, 4'hA, 1'b0, 1'b0, 8);
        hold(4'b1101, 4'hC, 1'b0, 1'b0, 8);
        hold(4'b1110, 4'hD, 1'b0, 1'b0, 8);
        chk("rev_fv_cnt", 32'(fv_cnt - f0), 32'd1);
        chk("rev_nib2",   32'(hexs0[11:8]), 32'hA);

        // Illegal anode patterns and error clearing.
        hold(4'b1110, 4'h3, 1'b0, 1'b0, 8);
        hx_save = hexs0;
        sn_save = seen0;
        hold(4'b1100, 4'hE, 1'b0, 1'b0, 6);
        chk("ill_err",  32'(err0),  32'h1);
        chk("ill_seen", 32'(seen0), 32'(sn_save));
        chk("ill_hexs", 32'(hexs0), 32'(hx_save));
        hold(4'b1010, 4'h1, 1'b0, 1'b0, 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ill_setwins", 32'(err0), 32'h1);
        hold(4'b1111, 4'h0, 1'b0, 1'b0, 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ill_clr", 32'(err0), 32'h0);

        // Long blank between digits, then finish the frame.
        f0 = fv_cnt;
        hold(4'b1111, 4'h0, 1'b0, 1'b0, 20);
        chk("blank_err",  32'(err0),  32'h0);
        chk("blank_seen", 32'(seen0), 32'(sn_save));
        hold(4'b1101, 4'h4, 1'b1, 1'b0, 8);
        hold(4'b1111, 4'h0, 1'b0, 1'b0, 20);
        hold(4'b1011, 4'h5, 1'b0, 1'b1, 8);
        hold(4'b0111, 4'h6, 1'b1, 1'b1, 8);
        chk("blank_fv_cnt", 32'(fv_cnt - f0), 32'd1);
        chk("blank_hexs",   32'(hexs0), 32'h6543);

        // Long illegal hold: clear mid-hold, the saturated run must not set it again.
        hold(4'b0101, 4'h0, 1'b0, 1'b0, 10);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        hold(4'b0101, 4'h0, 1'b0, 1'b0, 290);
        chk("sat_err", 32'(err0), 32'h0);

        // Reset mid-frame after three digits.
        hold(4'b1110, 4'h7, 1'b0, 1'b0, 8);
        hold(4'b1101, 4'h8, 1'b0, 1'b0, 8);
        hold(4'b1011, 4'h9, 1'b0, 1'b0, 8);
        rst = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) model_reset(i);
        chk("mrst_seen", 32'(seen0), 32'h0);
        chk("mrst_hexs", 32'(hexs0), 32'h0);
        chk("mrst_s1_hexs", 32'(hexs1), 32'h0);
        hold(4'b1111, 4'h0, 1'b0, 1'b0, 2);
        rst = 1'b0;
        hold(4'b0111, 4'h2, 1'b0, 1'b0, 8);
        chk("mrst_partial", 32'(hexs0), 32'h0);
        hold(4'b1110, 4'hF, 1'b1, 1'b1, 8);
        hold(4'b1011, 4'h1, 1'b0, 1'b0, 8);
        hold(4'b1101, 4'h0, 1'b1, 1'b0, 8);
        chk("mrst_frame", 32'(hexs0), 32'h210F);
        chk("mrst_point", 32'(point0), 32'b0011);
        chk("mrst_les",   32'(les0), 32'b0001);

        // One-cycle digits: only the edge-capture build assembles this frame.
        hx_save = hexs0;
        hold(4'b1110, 4'hC, 1'b0, 1'b0, 1);
        hold(4'b1101, 4'hD, 1'b0, 1'b0, 1);
        hold(4'b1011, 4'hE, 1'b0, 1'b0, 1);
        hold(4'b0111, 4'hF, 1'b0, 1'b0, 1);
        hold(4'b1111, 4'h0, 1'b0, 1'b0, 3);
        chk("edge_s1_hexs", 32'(hexs1), 32'hFEDC);
        chk("edge_s4_hexs", 32'(hexs0), 32'(hx_save));
        chk("edge_s4_seen", 32'(seen0), 32'h0);

        // Randomised bus activity.
        for (int it = 0; it < 1200; it++) begin
            int r, n;
            r = $urandom_range(0, 9);
            if (r == 6) begin
                ra = 4'b1111;
            end else if (r == 7) begin
                do ra = 4'($urandom); while ($countones(ra) > 2);
            end else begin
                ra = ~(4'b0001 << $urandom_range(0, 3));
            end
            an  = ra;
            hex = 4'($urandom);
            pp  = 1'($urandom);
            le  = 1'($urandom);
            n   = $urandom_range(1, 10);
            for (int c = 0; c < n; c++) begin
                clr = ($urandom_range(0, 15) == 0);
                if (rst) rst = 1'b0;
                else if ($urandom_range(0, 499) == 0) rst = 1'b1;
                tick();
            end
        end
        clr = 1'b0;
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
